// File: rtl/pcie_tx_symbol_scheduler.sv
// Single-lane PCIe TX symbol scheduler: merges TLP, DLLP and SKP sources into a byte+K stream.
// Optional EIOS/electrical-idle support is compiled in with `define PCIE_TX_EIOS_EN.
module pcie_tx_symbol_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_MAX_PEND = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       tlp_valid,
  input  logic [7:0] tlp_data,
  input  logic       tlp_last,
  output logic       tlp_ready,
  input  logic       dllp_valid,
  input  logic [7:0] dllp_data,
  output logic       dllp_ready,
  input  logic       ei_req,
  output logic       ei_active,
  output logic [7:0] sym_data,
  output logic       sym_k,
  output logic       underrun,
  output logic       skp_overflow
);

  localparam int unsigned CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int unsigned PW = $clog2(SKP_MAX_PEND + 1);

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;

  typedef enum logic [3:0] {
    ARB,
    TLP_BODY,
    TLP_END,
    TLP_FLUSH,
    DLLP_BODY,
    DLLP_END,
    DLLP_FLUSH,
    SKP
`ifdef PCIE_TX_EIOS_EN
    , EIOS,
    EI
`endif
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    idx, idx_nx;
  logic [CW-1:0] skp_cnt;
  logic [PW-1:0] pending;
  logic [7:0]    data_nx;
  logic          k_nx, ur_nx, dispatch, wrap, freeze;

`ifdef PCIE_TX_EIOS_EN
  assign freeze    = (state == EI);
  assign ei_active = (state == EI);
`else
  logic unused_ei_req;
  assign unused_ei_req = ei_req;
  assign freeze        = 1'b0;
  assign ei_active     = 1'b0;
`endif

  assign wrap = !freeze && (skp_cnt == CW'(SKP_INTERVAL - 1));

  // ARB emits the first symbol of the chosen sequence itself, so END/SKP -> ARB -> header is gapless.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    data_nx    = 8'h00;
    k_nx       = 1'b0;
    ur_nx      = 1'b0;
    dispatch   = 1'b0;
    tlp_ready  = 1'b0;
    dllp_ready = 1'b0;
    case (state)
      ARB: begin
`ifdef PCIE_TX_EIOS_EN
        if (ei_req) begin
          data_nx  = K_COM;
          k_nx     = 1'b1;
          idx_nx   = 3'd1;
          state_nx = EIOS;
        end else
`endif
        if (pending != '0) begin
          data_nx  = K_COM;
          k_nx     = 1'b1;
          dispatch = 1'b1;
          idx_nx   = 3'd1;
          state_nx = SKP;
        end else if (dllp_valid) begin
          data_nx  = K_SDP;
          k_nx     = 1'b1;
          idx_nx   = '0;
          state_nx = DLLP_BODY;
        end else if (tlp_valid) begin
          data_nx  = K_STP;
          k_nx     = 1'b1;
          state_nx = TLP_BODY;
        end
      end
      TLP_BODY: begin
        if (tlp_valid) begin
          tlp_ready = tx_en;
          data_nx   = tlp_data;
          if (tlp_last) state_nx = TLP_END;
        end else begin
          data_nx  = K_EDB;
          k_nx     = 1'b1;
          ur_nx    = 1'b1;
          state_nx = TLP_FLUSH;
        end
      end
      TLP_END: begin
        data_nx  = K_END;
        k_nx     = 1'b1;
        state_nx = ARB;
      end
      TLP_FLUSH: begin
        if (tlp_valid) begin
          tlp_ready = tx_en;
          if (tlp_last) state_nx = ARB;
        end
      end
      DLLP_BODY: begin
        if (dllp_valid) begin
          dllp_ready = tx_en;
          data_nx    = dllp_data;
          idx_nx     = idx + 3'd1;
          if (idx == 3'd5) state_nx = DLLP_END;
        end else begin
          data_nx  = K_EDB;
          k_nx     = 1'b1;
          ur_nx    = 1'b1;
          state_nx = DLLP_FLUSH;
        end
      end
      DLLP_END: begin
        data_nx  = K_END;
        k_nx     = 1'b1;
        state_nx = ARB;
      end
      // idx keeps the count of accepted DLLP bytes so the flush stops at six in total.
      DLLP_FLUSH: begin
        if (dllp_valid) begin
          dllp_ready = tx_en;
          idx_nx     = idx + 3'd1;
          if (idx == 3'd5) state_nx = ARB;
        end
      end
      SKP: begin
        data_nx = K_SKP;
        k_nx    = 1'b1;
        idx_nx  = idx + 3'd1;
        if (idx == 3'd3) state_nx = ARB;
      end
`ifdef PCIE_TX_EIOS_EN
      EIOS: begin
        data_nx = K_IDL;
        k_nx    = 1'b1;
        idx_nx  = idx + 3'd1;
        if (idx == 3'd3) state_nx = EI;
      end
      EI: begin
        if (!ei_req) state_nx = ARB;
      end
`endif
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB;
      idx          <= '0;
      skp_cnt      <= '0;
      pending      <= '0;
      sym_data     <= '0;
      sym_k        <= 1'b0;
      underrun     <= 1'b0;
      skp_overflow <= 1'b0;
    end else if (tx_en) begin
      state    <= state_nx;
      idx      <= idx_nx;
      sym_data <= data_nx;
      sym_k    <= k_nx;
      underrun <= ur_nx;
      if (!freeze) skp_cnt <= wrap ? '0 : skp_cnt + CW'(1);
      if (wrap && !dispatch && pending != PW'(SKP_MAX_PEND)) pending <= pending + PW'(1);
      else if (dispatch && !wrap)                            pending <= pending - PW'(1);
      if (wrap && pending == PW'(SKP_MAX_PEND)) skp_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_tx_symbol_scheduler.sv
// Directed bench for pcie_tx_symbol_scheduler: default instance plus a SKP_INTERVAL=16 instance.
module tb_pcie_tx_symbol_scheduler;

  typedef logic [8:0] sym_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n, tx_en, tlp_valid, tlp_last, dllp_valid, ei_req;
  logic [7:0] tlp_data, dllp_data;

  logic       tlp_ready, dllp_ready, ei_active, sym_k, underrun, skp_overflow;
  logic [7:0] sym_data;
  logic       s_tlp_ready, s_dllp_ready, s_ei_active, s_sym_k, s_underrun, s_skp_overflow;
  logic [7:0] s_sym_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbytes[128];
  logic [7:0] dbytes[6];
  int  t_len, t_idx, gap_idx, gap_left, d_len, d_idx, ready_cnt, ready_off;
  bit  use_skp, gate;
  logic [8:0] cap[$];
  bit  cap_ur[$];
  bit  cap_en[$];

  always #5 clk = ~clk;

  pcie_tx_symbol_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ready(tlp_ready),
    .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(dllp_ready),
    .ei_req(ei_req), .ei_active(ei_active),
    .sym_data(sym_data), .sym_k(sym_k), .underrun(underrun), .skp_overflow(skp_overflow)
  );

  pcie_tx_symbol_scheduler #(.SKP_INTERVAL(16), .SKP_MAX_PEND(3)) dut_skp (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ready(s_tlp_ready),
    .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(s_dllp_ready),
    .ei_req(ei_req), .ei_active(s_ei_active),
    .sym_data(s_sym_data), .sym_k(s_sym_k), .underrun(s_underrun), .skp_overflow(s_skp_overflow)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int start, input sym_q_t e);
    for (int i = 0; i < e.size(); i++) begin
      logic [31:0] act;
      act = 32'hDEAD_BEEF;
      if (start + i >= 0 && start + i < cap.size()) act = {23'd0, cap[start + i]};
      check($sformatf("%s[%0d]", tag, i), act, {23'd0, e[i]});
    end
  endtask

  function automatic int find_sym(input logic [8:0] s);
    for (int i = 0; i < cap.size(); i++)
      if (cap[i] === s) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; tx_en = 1'b1;
    tlp_valid = 1'b0; tlp_last = 1'b0; tlp_data = '0;
    dllp_valid = 1'b0; dllp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic new_test();
    cap.delete(); cap_ur.delete(); cap_en.delete();
    ready_cnt = 0; ready_off = 0;
    t_len = 0; t_idx = 0; d_len = 0; d_idx = 0;
    gap_idx = -1; gap_left = 0; gate = 0; use_skp = 0;
    do_reset();
  endtask

  // One loop iteration per clock: drive after the edge, sample at negedge, advance on handshake.
  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic rdy_t, rdy_d;
      bit stall;
      tx_en      = gate ? (c % 3 != 2) : 1'b1;
      stall      = (t_idx == gap_idx) && (gap_left > 0);
      tlp_valid  = (t_idx < t_len) && !stall;
      tlp_data   = tbytes[t_idx < 128 ? t_idx : 0];
      tlp_last   = (t_idx == t_len - 1);
      dllp_valid = (d_idx < d_len);
      dllp_data  = dbytes[d_idx < 6 ? d_idx : 0];
      @(negedge clk);
      rdy_t = use_skp ? s_tlp_ready : tlp_ready;
      rdy_d = use_skp ? s_dllp_ready : dllp_ready;
      cap.push_back(use_skp ? {s_sym_k, s_sym_data} : {sym_k, sym_data});
      cap_ur.push_back(use_skp ? s_underrun : underrun);
      cap_en.push_back(tx_en);
      if (rdy_t) ready_cnt++;
      if (!tx_en && (rdy_t || rdy_d)) ready_off++;
      @(posedge clk);
      if (rdy_t) t_idx++;
      if (rdy_d) d_idx++;
      if (stall) gap_left--;
      #1;
    end
  endtask

  task automatic skp_test(input string tag, input int n, input int ncyc, input sym_q_t e, input bit ovf);
    int p;
    new_test();
    use_skp = 1;
    for (int i = 0; i < n; i++) tbytes[i] = 8'(i + 1);
    t_len = n;
    run(ncyc);
    p = find_sym(9'h1FB);
    check({tag, "_stp_found"}, 32'(p >= 0), 1);
    if (p < 0) p = 100000;
    check_seq({tag, "_first"}, p + 1, {9'h001});
    check_seq({tag, "_tail"}, p + n, {9'(8'(n)), 9'h1FD});
    check_seq({tag, "_skp"}, p + n + 2, e);
    check({tag, "_ready_cnt"}, 32'(ready_cnt), 32'(n));
    check({tag, "_overflow"}, 32'(s_skp_overflow), 32'(ovf));
  endtask

  initial begin
    int p, cnt;
    sym_q_t comp;
    ei_req = 1'b0;

    // Reset state
    new_test();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sym", {23'd0, sym_k, sym_data}, 0);
    check("rst_ready", {30'd0, tlp_ready, dllp_ready}, 0);
    check("rst_flags", {29'd0, ei_active, underrun, skp_overflow}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run(6);
    cnt = 0;
    foreach (cap[i]) if (cap[i] !== 9'h000) cnt++;
    check("idle_stream", 32'(cnt), 0);
    check("idle_ready", 32'(ready_cnt), 0);

    // 3-byte TLP
    new_test();
    tbytes[0] = 8'hAA; tbytes[1] = 8'hBB; tbytes[2] = 8'hCC; t_len = 3;
    run(12);
    p = find_sym(9'h1FB);
    check("tlp3_stp_found", 32'(p >= 0), 1);
    if (p < 0) p = 100000;
    check_seq("tlp3", p + 1, {9'h0AA, 9'h0BB, 9'h0CC, 9'h1FD, 9'h000});
    check("tlp3_ready_cnt", 32'(ready_cnt), 3);

    // DLLP and TLP together: DLLP wins, TLP follows END with no gap
    new_test();
    dbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}; d_len = 6;
    tbytes[0] = 8'h77; t_len = 1;
    run(16);
    p = find_sym(9'h15C);
    check("b2b_sdp_found", 32'(p >= 0), 1);
    if (p < 0) p = 100000;
    check_seq("b2b", p + 1, {9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066,
                             9'h1FD, 9'h1FB, 9'h077, 9'h1FD});
    check("b2b_dllp_consumed", 32'(d_idx), 6);

    // tx_en gating during a TLP
    new_test();
    gate = 1;
    tbytes[0] = 8'hAA; tbytes[1] = 8'hBB; tbytes[2] = 8'hCC; t_len = 3;
    run(20);
    check("gate_ready_off", 32'(ready_off), 0);
    check("gate_ready_cnt", 32'(ready_cnt), 3);
    cnt = 0;
    comp.delete();
    for (int c = 1; c < cap.size(); c++) begin
      if (!cap_en[c - 1] && cap[c] !== cap[c - 1]) cnt++;
      if (cap_en[c - 1]) comp.push_back(cap[c]);
    end
    check("gate_hold", 32'(cnt), 0);
    cap = comp;
    p = find_sym(9'h1FB);
    check("gate_stp_found", 32'(p >= 0), 1);
    if (p < 0) p = 100000;
    check_seq("gate", p + 1, {9'h0AA, 9'h0BB, 9'h0CC, 9'h1FD});

    // TLP underrun after 2 of 5 bytes, remaining bytes drained as idle
    new_test();
    tbytes[0] = 8'h10; tbytes[1] = 8'h20; tbytes[2] = 8'h30; tbytes[3] = 8'h40; tbytes[4] = 8'h50;
    t_len = 5; gap_idx = 2; gap_left = 2;
    run(16);
    p = find_sym(9'h1FB);
    check("ur_stp_found", 32'(p >= 0), 1);
    if (p < 0) p = 100000;
    check_seq("ur", p + 1, {9'h010, 9'h020, 9'h1FE, 9'h000, 9'h000, 9'h000, 9'h000});
    check("ur_pulse_at_edb", 32'((p + 3 < cap_ur.size()) ? cap_ur[p + 3] : 1'b0), 1);
    cnt = 0;
    foreach (cap_ur[i]) if (cap_ur[i]) cnt++;
    check("ur_pulse_cnt", 32'(cnt), 1);
    check("ur_drained", 32'(ready_cnt), 5);

    // SKP scheduling with SKP_INTERVAL=16: two pending sets, then saturation
    skp_test("skp40", 40, 60, {9'h1BC, 9'h11C, 9'h11C, 9'h11C, 9'h1BC, 9'h11C, 9'h11C, 9'h11C}, 1'b0);
    skp_test("skp70", 70, 90, {9'h1BC, 9'h11C, 9'h11C, 9'h11C, 9'h1BC, 9'h11C, 9'h11C, 9'h11C,
                               9'h1BC, 9'h11C, 9'h11C, 9'h11C}, 1'b1);
    do_reset();
    @(negedge clk);
    check("ovf_cleared_by_reset", 32'(s_skp_overflow), 0);

`ifdef PCIE_TX_EIOS_EN
    // EIOS after a TLP boundary, then electrical idle and exit
    new_test();
    tbytes[0] = 8'hAA; tbytes[1] = 8'hBB; tbytes[2] = 8'hCC; t_len = 3;
    run(3);
    ei_req = 1'b1;
    run(14);
    p = find_sym(9'h1FB);
    check("eios_stp_found", 32'(p >= 0), 1);
    if (p < 0) p = 100000;
    check_seq("eios", p + 1, {9'h0AA, 9'h0BB, 9'h0CC, 9'h1FD, 9'h1BC, 9'h17C, 9'h17C, 9'h17C, 9'h000});
    check("ei_active_on", 32'(ei_active), 1);
    tx_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ei_hold_gated", {22'd0, ei_active, sym_k, sym_data}, 32'h200);
    @(posedge clk); #1;
    tx_en = 1'b1; ei_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ei_active_off", 32'(ei_active), 0);
`else
    // ei_req has no effect when EIOS support is compiled out
    new_test();
    ei_req = 1'b1;
    tbytes[0] = 8'hAA; tbytes[1] = 8'hBB; tbytes[2] = 8'hCC; t_len = 3;
    run(12);
    p = find_sym(9'h1FB);
    check("noei_stp_found", 32'(p >= 0), 1);
    if (p < 0) p = 100000;
    check_seq("noei", p + 1, {9'h0AA, 9'h0BB, 9'h0CC, 9'h1FD, 9'h000});
    check("noei_active", 32'(ei_active), 0);
    ei_req = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pcie_tx_symbol_scheduler.md
Name: pcie_tx_symbol_scheduler

Overview:
- Single-lane Gen1/Gen2 transmit-side symbol scheduler.
- Sits between the data-link layer and the 8b/10b encoder.
- Merges three symbol sources into one byte+K-flag stream, one symbol per enabled clock:
  - TLP stream, framed STP…END
  - DLLP stream, framed SDP + 6 bytes + END
  - periodic SKP ordered sets
- Inserts logical idle (D0.0) when no source is pending; nullifies underrun TLPs with EDB.

Parameters:
- SKP_INTERVAL, 1180: number of tx_en symbols between SKP ordered-set schedules.
- SKP_MAX_PEND, 3: saturation limit of the pending-SKP counter.

Ports:
- clk  in  1  symbol clock
- rst_n  in  1  synchronous active-low reset
- tx_en  in  1  symbol strobe; the block advances only when high
- tlp_valid  in  1  TLP byte valid
- tlp_data  in  8  TLP byte
- tlp_last  in  1  last TLP byte
- tlp_ready  out  1  TLP byte consumed this cycle
- dllp_valid  in  1  DLLP byte valid
- dllp_data  in  8  DLLP byte (exactly 6 per DLLP)
- dllp_ready  out  1  DLLP byte consumed this cycle
- ei_req  in  1  request electrical idle (EIOS)
- ei_active  out  1  transmitter in electrical idle
- sym_data  out  8  registered symbol
- sym_k  out  1  registered K flag
- underrun  out  1  one-cycle pulse: TLP/DLLP underrun, EDB sent
- skp_overflow  out  1  sticky: pending SKP counter saturated

Behaviour:
- Reset: all state cleared; outputs after reset as follows:
  - state ARB; sym_data=0x00, sym_k=0
  - tlp_ready=0, dllp_ready=0, ei_active=0, underrun=0, skp_overflow=0
  - skp counter=0, pending=0
- Gating: every state/output register updates only when tx_en=1. When tx_en=0, ready outputs are 0 and everything holds.
- Ready outputs are combinational: tlp_ready = tx_en & (state==TLP_BODY | TLP_FLUSH) & tlp_valid; dllp_ready is analogous for DLLP_BODY.
- Latency: a byte accepted in cycle N appears on sym_data in cycle N+1.
- K-codes:
  - COM=BC, STP=FB, SDP=5C, END=FD, EDB=FE
  - SKP=1C, IDL=7C
  - logical idle = 00 with K=0
- SKP timer:
  - Counts tx_en cycles from 0 to SKP_INTERVAL-1, then wraps.
  - On wrap, pending increments, saturating at SKP_MAX_PEND.
  - A wrap while pending==SKP_MAX_PEND sets skp_overflow.
  - Same-cycle wrap and SKP dispatch: pending is unchanged (increment and decrement cancel).
- Arbitration (state ARB, also evaluated in the last symbol of END/SKP so packets can go back to back). Priority is:
  1. ei_req (macro on) → EIOS
  2. pending>0 → SKP
  3. dllp_valid → DLLP_HDR
  4. tlp_valid → TLP_HDR
  5. otherwise emit logical idle.
- SKP: emit COM, SKP, SKP, SKP (4 cycles, index counter); pending decrements at the COM cycle.
- DLLP:
  - SDP, then 6 bytes from DLLP_BODY, then END.
  - dllp_valid low mid-body → emit EDB, pulse underrun, go to DLLP_FLUSH (output idle, consume remaining bytes up to 6 total).
- TLP:
  - STP, then TLP_BODY bytes until tlp_last is accepted, then END.
  - tlp_valid low mid-body → emit EDB, pulse underrun, go to TLP_FLUSH.
  - TLP_FLUSH outputs logical idle and discards bytes until tlp_last is accepted, then goes to ARB.
- Preemption: a packet in progress is never preempted. SKP/EIOS wait for a boundary.
- Reset mid-packet: the symbol stream aborts immediately to idle (00). No END/EDB is generated.
- Zero-length TLP is impossible: the first accepted byte may carry tlp_last, and STP,b,END is legal.

Optional Feature:
- Macro PCIE_TX_EIOS_EN.
- Defined:
  - ei_req is sampled at arbitration. The block emits COM, IDL, IDL, IDL, then enters EI.
  - In EI: ei_active=1, sym_data=00, sym_k=0, SKP timer frozen, both readies 0.
  - ei_req low in EI → ei_active=0 next cycle, return to ARB. The SKP counter resumes from its frozen value.
- Undefined: ei_req is ignored, ei_active is tied 0, and the EIOS/EI states are absent.

Test Plan:
- Reset with all inputs 0, tx_en=1 → sym_data=00, sym_k=0 every cycle, readies 0.
- 3-byte TLP (AA, BB, CC, last on CC) → symbols FB(K), AA, BB, CC, FD(K); tlp_ready high for exactly 3 cycles.
- DLLP and TLP valid together at idle → SDP, 6 DLLP bytes, END, then immediately STP with no idle gap.
- SKP_INTERVAL=16 with a continuous 40-byte TLP → SKP set (BC, 1C, 1C, 1C all K) appears right after END; pending reaches 2 and both sets go out back to back.
- tlp_valid dropped after 2 bytes of 5 → FB, b0, b1, FE(K); underrun pulses 1 cycle; remaining 3 bytes drained while the output is 00.
- With PCIE_TX_EIOS_EN, ei_req=1 during a TLP → TLP completes with END, then BC, 7C, 7C, 7C (K); ei_active=1; tx_en toggling holds state; ei_req=0 → ei_active=0 next cycle.
